// File: rtl/ga21_dma_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ga21_pkg
//  Description : Shared types and constants for the GA21 DMA scheduler:
//                scheduler state encoding, status-word bit positions and
//                default watchdog limits.
//  Revision    : 1.0 - initial release
// ============================================================================
package ga21_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PEND = 3'd1,
        KICK = 3'd2,
        ACK  = 3'd3,
        RUN  = 3'd4,
        DONE = 3'd5
    } dma_state_t;

    // Status word layout
    localparam int c_st_queued   = 0;
    localparam int c_st_ackfail  = 1;
    localparam int c_st_timeout  = 2;
    localparam int c_st_drop_lsb = 4;
    localparam int c_st_drop_msb = 7;
    localparam int c_st_done_lsb = 8;
    localparam int c_st_done_msb = 15;

    // Watchdog defaults and counter width
    localparam int unsigned c_def_timeout    = 8191;
    localparam int unsigned c_def_ack_window = 4;
    localparam int unsigned c_wd_w           = 16;

endpackage
`default_nettype wire

// File: rtl/ga21_dma_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : ga21_dma_sched_if
//  Description : CPU-side / GA21-side signal bundle of the DMA scheduler.
//                slave  : scheduler view (requests in, kick/wait/irq out)
//                master : environment view (CPU decode, video, GA21)
//  Revision    : 1.0 - initial release
// ============================================================================
interface ga21_dma_sched_if;
    logic        kick_req;   // CPU write to GA21 offset 4, one-clk pulse
    logic        cfg_wr;     // scheduler config write, one-clk pulse
    logic [2:0]  cfg_din;    // [0] deferred, [1] irq enable, [2] clear status
    logic        vblank;     // video vblank level
    logic        ga21_busy;  // GA21 busy
    logic        buf_cs;     // CPU chip-select of GA21 buffer window
    logic        irq_ack;    // irq clear pulse
    logic        ga21_kick;  // kick pulse to GA21
    logic        cpu_wait;   // CPU wait request
    logic        irq;        // completion interrupt
    logic [15:0] status;     // counters and sticky flags

    modport slave (
        input  kick_req, cfg_wr, cfg_din, vblank, ga21_busy, buf_cs, irq_ack,
        output ga21_kick, cpu_wait, irq, status
    );

    modport master (
        output kick_req, cfg_wr, cfg_din, vblank, ga21_busy, buf_cs, irq_ack,
        input  ga21_kick, cpu_wait, irq, status
    );
endinterface
`default_nettype wire

// File: rtl/ga21_dma_sched_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : ga21_dma_watchdog
//  Description : Loadable up-counter with enable and terminal flag. o_term is
//                high while the current enabled cycle is the i_limit-th one
//                since the last load, so the caller can abort on that cycle.
//  Ports       : clk, reset   - clock, synchronous active-high reset
//                i_load       - clear count to 0 (wins over i_en)
//                i_en         - count this cycle
//                i_limit      - terminal count
//                o_term       - count has reached i_limit-1
//  Revision    : 1.0 - initial release
// ============================================================================
module ga21_dma_watchdog
    import ga21_pkg::*;
#(
    parameter int unsigned WIDTH = c_wd_w
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_limit,
    output logic             o_term
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (i_load) begin
            count_d = '0;
        end else if (i_en) begin
            count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Terminal term does not include i_en so the caller's enable logic can
    // depend on it without forming a combinational loop.
    assign o_term = (count_q == (i_limit - {{(WIDTH-1){1'b0}}, 1'b1}));

endmodule
`default_nettype wire

// File: rtl/ga21_dma_sched.sv
`default_nettype none
// ============================================================================
//  Module      : ga21_dma_sched
//  Description : Schedules GA21 copy starts (immediate or at next vblank),
//                stalls CPU buffer accesses during a copy, queues one
//                follow-up request, supervises GA21 with ack/run watchdogs
//                and raises a completion interrupt.
//  Ports       : clk, reset - clock, synchronous active-high reset
//                ce         - clock enable shared with GA21 (run watchdog)
//                bus        - request/config/status bundle (slave modport)
//  Revision    : 1.0 - initial release
// ============================================================================
module ga21_dma_sched
    import ga21_pkg::*;
#(
    parameter int unsigned TIMEOUT    = c_def_timeout,
    parameter int unsigned ACK_WINDOW = c_def_ack_window
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ce,
    ga21_dma_sched_if.slave bus
);

    localparam logic [c_wd_w-1:0] c_run_limit = c_wd_w'(TIMEOUT);
    localparam logic [c_wd_w-1:0] c_ack_limit = c_wd_w'(ACK_WINDOW);

    dma_state_t  state_q, state_d;
    logic        mode_q, mode_d;
    logic        irq_en_q, irq_en_d;
    logic        irq_q, irq_d;
    logic        queued_q, queued_d;
    logic        ackfail_q, ackfail_d;
    logic        timeout_q, timeout_d;
    logic        run_err_q, run_err_d;
    logic        vblank_dly_q, vblank_dly_d;
    logic [7:0]  done_cnt_q, done_cnt_d;
    logic [3:0]  drop_cnt_q, drop_cnt_d;

    logic              w_vblank_rise;
    logic              w_clr_status;
    logic              w_ackfail_set;
    logic              w_timeout_set;
    logic              w_wd_load;
    logic              w_wd_en;
    logic              w_wd_term;
    logic [c_wd_w-1:0] w_wd_limit;
    logic [15:0]       w_status;

    assign w_vblank_rise = bus.vblank & ~vblank_dly_q;
    assign w_clr_status  = bus.cfg_wr & bus.cfg_din[2];
    // One counter serves both checks; only one of ACK/RUN is active at a time.
    assign w_wd_limit    = (state_q == RUN) ? c_run_limit : c_ack_limit;

    ga21_dma_watchdog #(
        .WIDTH (c_wd_w)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_wd_load),
        .i_en    (w_wd_en),
        .i_limit (w_wd_limit),
        .o_term  (w_wd_term)
    );

    always_comb begin
        state_d       = state_q;
        queued_d      = queued_q;
        run_err_d     = run_err_q;
        done_cnt_d    = done_cnt_q;
        drop_cnt_d    = drop_cnt_q;
        w_ackfail_set = 1'b0;
        w_timeout_set = 1'b0;
        w_wd_load     = 1'b0;
        w_wd_en       = 1'b0;
        irq_d         = irq_q;

        case (state_q)
            IDLE: begin
                if (bus.kick_req) begin
                    state_d = mode_q ? PEND : KICK;
                end
            end
            PEND: begin
                if (w_vblank_rise) begin
                    state_d = KICK;
                end
            end
            KICK: begin
                w_wd_load = 1'b1;
                state_d   = ACK;
            end
            ACK: begin
                w_wd_en = 1'b1;
                if (bus.ga21_busy) begin
                    w_wd_load = 1'b1;
                    state_d   = RUN;
                end else if (w_wd_term) begin
                    w_ackfail_set = 1'b1;
                    run_err_d     = 1'b1;
                    state_d       = DONE;
                end
            end
            RUN: begin
                w_wd_en = ce;
                if (!bus.ga21_busy) begin
                    state_d = DONE;
                end else if (ce && w_wd_term) begin
                    w_timeout_set = 1'b1;
                    run_err_d     = 1'b1;
                    state_d       = DONE;
                end
            end
            DONE: begin
                if (!run_err_q) begin
                    done_cnt_d = done_cnt_q + 8'd1;
                end
                run_err_d = 1'b0;
                // A request arriving during DONE is launched like a queued one.
                if (queued_q || bus.kick_req) begin
                    state_d = mode_q ? PEND : KICK;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // One-deep request queue; DONE always consumes the slot.
        if (bus.kick_req && (state_q != IDLE) && queued_q) begin
            if (drop_cnt_q != 4'hF) begin
                drop_cnt_d = drop_cnt_q + 4'd1;
            end
        end
        if (state_q == DONE) begin
            queued_d = 1'b0;
        end else if (bus.kick_req && (state_q != IDLE)) begin
            queued_d = 1'b1;
        end
        if (w_clr_status) begin
            drop_cnt_d = 4'd0;
        end

        // irq: clears first, set last so a coinciding set wins.
        if (bus.irq_ack) begin
            irq_d = 1'b0;
        end
        if (bus.cfg_wr && !bus.cfg_din[1]) begin
            irq_d = 1'b0;
        end
        if ((state_q == DONE) && irq_en_q) begin
            irq_d = 1'b1;
        end
    end

    always_comb begin
        mode_d       = bus.cfg_wr ? bus.cfg_din[0] : mode_q;
        irq_en_d     = bus.cfg_wr ? bus.cfg_din[1] : irq_en_q;
        vblank_dly_d = bus.vblank;
        ackfail_d    = (ackfail_q & ~w_clr_status) | w_ackfail_set;
        timeout_d    = (timeout_q & ~w_clr_status) | w_timeout_set;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            mode_q       <= 1'b0;
            irq_en_q     <= 1'b0;
            irq_q        <= 1'b0;
            queued_q     <= 1'b0;
            ackfail_q    <= 1'b0;
            timeout_q    <= 1'b0;
            run_err_q    <= 1'b0;
            vblank_dly_q <= 1'b0;
            done_cnt_q   <= 8'd0;
            drop_cnt_q   <= 4'd0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            irq_en_q     <= irq_en_d;
            irq_q        <= irq_d;
            queued_q     <= queued_d;
            ackfail_q    <= ackfail_d;
            timeout_q    <= timeout_d;
            run_err_q    <= run_err_d;
            vblank_dly_q <= vblank_dly_d;
            done_cnt_q   <= done_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    always_comb begin
        w_status                              = 16'd0;
        w_status[c_st_done_msb:c_st_done_lsb] = done_cnt_q;
        w_status[c_st_drop_msb:c_st_drop_lsb] = drop_cnt_q;
        w_status[c_st_timeout]                = timeout_q;
        w_status[c_st_ackfail]                = ackfail_q;
        w_status[c_st_queued]                 = queued_q;
    end

    assign bus.ga21_kick = (state_q == KICK);
    // Combinational from buf_cs so the wait meets the CPU strobe cycle.
    assign bus.cpu_wait  = bus.buf_cs &
                           ((state_q == KICK) || (state_q == ACK) || (state_q == RUN));
    assign bus.irq       = irq_q;
    assign bus.status    = w_status;

endmodule
`default_nettype wire

// File: tb/tb_ga21_dma_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ga21_dma_sched
//  Description : Directed self-checking bench for ga21_dma_sched. Inputs are
//                driven 1 time unit after each rising edge; outputs are
//                checked at the same point, i.e. after the edge settles.
//                The DUT runs with TIMEOUT=100 so the run watchdog is
//                reachable in a short run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ga21_dma_sched;

    logic clk = 1'b0;
    logic reset;
    logic ce;
    int   checks   = 0;
    int   failures = 0;

    ga21_dma_sched_if bus ();

    ga21_dma_sched #(
        .TIMEOUT    (100),
        .ACK_WINDOW (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic [2:0] din);
        bus.cfg_wr  = 1'b1;
        bus.cfg_din = din;
        tick(1);
        bus.cfg_wr  = 1'b0;
        bus.cfg_din = 3'b000;
    endtask

    initial begin
        reset         = 1'b1;
        ce            = 1'b1;
        bus.kick_req  = 1'b0;
        bus.cfg_wr    = 1'b0;
        bus.cfg_din   = 3'b000;
        bus.vblank    = 1'b0;
        bus.ga21_busy = 1'b0;
        bus.buf_cs    = 1'b1;
        bus.irq_ack   = 1'b0;
        tick(2);
        reset = 1'b0;

        // ---------------- reset state ----------------
        chk("reset_status", bus.status, 16'h0000);
        chk("reset_irq", {15'd0, bus.irq}, 16'd0);
        chk("reset_kick", {15'd0, bus.ga21_kick}, 16'd0);
        chk("reset_wait", {15'd0, bus.cpu_wait}, 16'd0);

        // ---------------- immediate mode ----------------
        bus.kick_req = 1'b1;
        tick(1);                       // KICK
        bus.kick_req = 1'b0;
        chk("imm_kick", {15'd0, bus.ga21_kick}, 16'd1);
        tick(1);                       // ACK, 1st cycle
        chk("imm_kick_pulse_len", {15'd0, bus.ga21_kick}, 16'd0);
        tick(1);                       // ACK, 2nd cycle: GA21 raises busy
        bus.ga21_busy = 1'b1;
        tick(1);                       // RUN
        chk("imm_wait_run", {15'd0, bus.cpu_wait}, 16'd1);
        bus.buf_cs = 1'b0;
        #1;
        chk("imm_wait_no_cs", {15'd0, bus.cpu_wait}, 16'd0);
        bus.buf_cs = 1'b1;
        // 120 clk in RUN but only 60 ce: must not trip the 100-ce watchdog
        for (int i = 0; i < 120; i++) begin
            ce = (i % 2 == 0);
            tick(1);
        end
        ce = 1'b1;
        chk("imm_ce_gating", bus.status, 16'h0000);
        chk("imm_wait_long_run", {15'd0, bus.cpu_wait}, 16'd1);
        bus.ga21_busy = 1'b0;
        tick(1);                       // DONE
        chk("imm_wait_done", {15'd0, bus.cpu_wait}, 16'd0);
        tick(1);                       // IDLE
        chk("imm_completed", bus.status, 16'h0100);
        chk("imm_irq_disabled", {15'd0, bus.irq}, 16'd0);

        // ---------------- deferred mode with irq ----------------
        cfg(3'b011);
        bus.kick_req = 1'b1;
        tick(1);                       // PEND
        bus.kick_req = 1'b0;
        chk("def_no_kick", {15'd0, bus.ga21_kick}, 16'd0);
        chk("def_pend_no_wait", {15'd0, bus.cpu_wait}, 16'd0);
        tick(10);
        chk("def_still_waiting", {15'd0, bus.ga21_kick}, 16'd0);
        bus.vblank = 1'b1;
        tick(1);                       // KICK
        chk("def_kick_at_vblank", {15'd0, bus.ga21_kick}, 16'd1);
        tick(1);                       // ACK
        bus.ga21_busy = 1'b1;
        tick(1);                       // RUN
        tick(5);
        bus.ga21_busy = 1'b0;
        bus.vblank    = 1'b0;
        tick(1);                       // DONE
        tick(1);                       // IDLE
        chk("def_irq_set", {15'd0, bus.irq}, 16'd1);
        chk("def_completed", bus.status, 16'h0200);
        bus.irq_ack = 1'b1;
        tick(1);
        bus.irq_ack = 1'b0;
        chk("def_irq_ack", {15'd0, bus.irq}, 16'd0);

        // ---------------- queue, ack/set collision ----------------
        cfg(3'b010);                   // immediate, irq enabled
        bus.kick_req = 1'b1;
        tick(1);                       // KICK
        bus.kick_req = 1'b0;
        tick(1);                       // ACK
        bus.ga21_busy = 1'b1;
        tick(1);                       // RUN
        for (int i = 0; i < 3; i++) begin
            bus.kick_req = 1'b1;
            tick(1);
            bus.kick_req = 1'b0;
            tick(1);
        end
        chk("q_queued_dropped", bus.status, 16'h0221);
        bus.ga21_busy = 1'b0;
        tick(1);                       // DONE
        bus.irq_ack = 1'b1;            // coincides with the irq set
        tick(1);                       // KICK for the queued request
        bus.irq_ack = 1'b0;
        chk("q_set_beats_ack", {15'd0, bus.irq}, 16'd1);
        chk("q_second_kick", {15'd0, bus.ga21_kick}, 16'd1);
        chk("q_after_first", bus.status, 16'h0320);
        tick(1);                       // ACK
        bus.ga21_busy = 1'b1;
        tick(1);                       // RUN
        bus.ga21_busy = 1'b0;
        tick(2);                       // DONE -> IDLE
        chk("q_total", bus.status, 16'h0420);
        chk("q_idle_wait", {15'd0, bus.cpu_wait}, 16'd0);

        // ---------------- drop saturation, clear, mode change in PEND ----
        bus.irq_ack = 1'b1;
        tick(1);
        bus.irq_ack = 1'b0;
        cfg(3'b011);
        bus.kick_req = 1'b1;
        tick(1);                       // PEND
        bus.kick_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus.kick_req = 1'b1;
            tick(1);
            bus.kick_req = 1'b0;
            tick(1);
        end
        chk("sat_dropped", bus.status, 16'h04F1);
        cfg(3'b110);                   // clear status, immediate, irq en
        chk("sat_cleared", bus.status, 16'h0401);
        tick(3);
        chk("pend_ignores_mode", {15'd0, bus.ga21_kick}, 16'd0);
        bus.vblank = 1'b1;
        tick(1);                       // KICK
        chk("pend_kick", {15'd0, bus.ga21_kick}, 16'd1);
        tick(1);                       // ACK
        bus.ga21_busy = 1'b1;
        tick(1);                       // RUN
        bus.ga21_busy = 1'b0;
        bus.vblank    = 1'b0;
        tick(2);                       // DONE -> KICK (queued, now immediate)
        chk("queued_immediate_kick", {15'd0, bus.ga21_kick}, 16'd1);
        chk("queued_status", bus.status, 16'h0500);

        // ---------------- ack-fail: GA21 never raises busy ----------------
        bus.irq_ack = 1'b1;
        tick(1);                       // ACK cycle 1
        bus.irq_ack = 1'b0;
        chk("af_irq_acked", {15'd0, bus.irq}, 16'd0);
        tick(3);                       // ACK cycle 4 (last allowed)
        chk("af_not_yet", bus.status, 16'h0500);
        chk("af_wait_in_ack", {15'd0, bus.cpu_wait}, 16'd1);
        tick(1);                       // DONE
        chk("af_sticky", bus.status, 16'h0502);
        chk("af_wait_released", {15'd0, bus.cpu_wait}, 16'd0);
        tick(1);                       // IDLE
        chk("af_irq", {15'd0, bus.irq}, 16'd1);
        chk("af_idle_no_kick", {15'd0, bus.ga21_kick}, 16'd0);
        cfg(3'b000);                   // disabling irq clears it
        chk("irq_disable_clears", {15'd0, bus.irq}, 16'd0);

        // ---------------- timeout ----------------
        bus.kick_req = 1'b1;
        tick(1);                       // KICK
        bus.kick_req = 1'b0;
        tick(1);                       // ACK
        bus.ga21_busy = 1'b1;
        tick(1);                       // RUN cycle 1
        tick(99);                      // RUN cycle 100
        chk("to_not_yet", bus.status, 16'h0502);
        chk("to_wait_run", {15'd0, bus.cpu_wait}, 16'd1);
        tick(1);                       // DONE
        chk("to_sticky", bus.status, 16'h0506);
        chk("to_wait_released", {15'd0, bus.cpu_wait}, 16'd0);
        tick(1);                       // IDLE
        chk("to_irq_disabled", {15'd0, bus.irq}, 16'd0);
        chk("to_idle", {15'd0, bus.cpu_wait}, 16'd0);
        bus.ga21_busy = 1'b0;
        cfg(3'b111);                   // clear status, deferred, irq en
        chk("clr_stickies", bus.status, 16'h0500);

        // ---------------- reset mid-RUN ----------------
        bus.kick_req = 1'b1;
        tick(1);                       // PEND
        bus.kick_req = 1'b0;
        bus.vblank   = 1'b1;
        tick(1);                       // KICK
        bus.vblank   = 1'b0;
        tick(1);                       // ACK
        bus.ga21_busy = 1'b1;
        tick(1);                       // RUN
        bus.kick_req = 1'b1;
        tick(1);
        bus.kick_req = 1'b0;
        chk("rst_pre_queued", bus.status, 16'h0501);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("rst_status", bus.status, 16'h0000);
        chk("rst_wait", {15'd0, bus.cpu_wait}, 16'd0);
        chk("rst_kick", {15'd0, bus.ga21_kick}, 16'd0);
        chk("rst_irq", {15'd0, bus.irq}, 16'd0);
        bus.ga21_busy = 1'b0;
        tick(2);
        chk("rst_no_queued_kick", {15'd0, bus.ga21_kick}, 16'd0);
        bus.kick_req = 1'b1;
        tick(1);                       // KICK: mode back to immediate
        bus.kick_req = 1'b0;
        chk("rst_new_kick", {15'd0, bus.ga21_kick}, 16'd1);
        tick(1);                       // ACK
        bus.ga21_busy = 1'b1;
        tick(1);                       // RUN
        bus.ga21_busy = 1'b0;
        tick(2);                       // DONE -> IDLE
        chk("rst_new_done", bus.status, 16'h0100);
        chk("rst_irq_en_cleared", {15'd0, bus.irq}, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
